// File: rtl/fetch_unit_pkg.sv
// Shared defaults and sizing helpers for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int unsigned PC_WIDTH_DEF    = 32;
    localparam int unsigned INST_WIDTH_DEF  = 32;
    localparam int unsigned FETCH_DEPTH_DEF = 2;
    localparam logic [31:0] RESET_ADDR_DEF  = 32'h0000_0000;
    localparam int unsigned INST_BYTES      = 4;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth > 0) ? $clog2(depth + 1) : 1;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a registered head (dout always shows the oldest entry).
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [WIDTH-1:0]             din_i,
    output logic [WIDTH-1:0]             dout_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is accepted only when the same cycle pops.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            // Head comes straight from din when the queue would otherwise be empty.
            if ((count_q - CNT_W'(do_pop)) == CNT_W'(0)) dout_d = din_i;
            else                                          dout_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    assign dout_o  = dout_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited bus requests, in-order
// response buffering and redirect squashing ahead of the decoder.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = PC_WIDTH_DEF,
    parameter int unsigned         INST_WIDTH = INST_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_ADDR = PC_WIDTH'(RESET_ADDR_DEF),
    parameter int unsigned         DEPTH      = FETCH_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ir_addr_valid,
    input  logic                  ir_addr_ready,
    output logic [PC_WIDTH-1:0]   ir_addr,
    input  logic                  ir_data_valid,
    output logic                  ir_data_ready,
    input  logic [INST_WIDTH-1:0] ir_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_pc
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

    logic [PC_WIDTH-1:0] pc_next_q, pc_next_d;
    logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [CNT_W-1:0]    kill_q, kill_d;
    logic                redirect_pending_q, redirect_pending_d;
    logic                issue_en_q;

    logic [PC_WIDTH-1:0] target;
    logic [OCC_W-1:0]    occupancy;
    logic                credit_ok;
    logic                addr_hs;
    logic                resp_ok;
    logic                resp_keep;
    logic                inst_pop;
    logic                unused_redirect_lsb;

    fetch_entry_t        push_entry;
    fetch_entry_t        head_entry;
    logic                fifo_empty, fifo_full;
    logic [CNT_W-1:0]    fifo_count;
    logic [PC_WIDTH-1:0] pcq_head;
    logic                pcq_empty, pcq_full;
    logic [CNT_W-1:0]    pcq_count;

    assign target              = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // A slot being consumed this cycle is already free for a new request; once
    // valid rises the occupancy can only shrink, so the request never drops.
    assign inst_pop      = inst_valid && inst_ready;
    assign occupancy     = OCC_W'(inflight_q) + OCC_W'(fifo_count) - OCC_W'(inst_pop);
    assign credit_ok     = occupancy < OCC_W'(DEPTH);
    assign ir_addr_valid = issue_en_q && (redirect_pending_q || credit_ok);
    assign ir_addr       = pc_next_q;
    assign ir_data_ready = 1'b1;

    assign addr_hs   = ir_addr_valid && ir_addr_ready;
    assign resp_ok   = ir_data_valid && !pcq_empty;
    assign resp_keep = resp_ok && (kill_q == '0) && !redirect;

    assign push_entry = '{pc: pcq_head, inst: ir_data};

    always_comb begin
        pc_next_d          = pc_next_q;
        redirect_pc_d      = redirect_pc_q;
        redirect_pending_d = redirect_pending_q;
        inflight_d         = inflight_q + CNT_W'(addr_hs) - CNT_W'(resp_ok);
        kill_d             = kill_q;

        if (resp_ok && (kill_q != '0)) kill_d = kill_q - CNT_W'(1);

        if (addr_hs) begin
            if (redirect_pending_q) begin
                // The held request belongs to the squashed stream.
                pc_next_d          = redirect_pc_q;
                kill_d             = kill_d + CNT_W'(1);
                redirect_pending_d = 1'b0;
            end else begin
                pc_next_d = pc_next_q + PC_WIDTH'(INST_BYTES);
            end
        end

        // Everything still outstanding after this cycle is stale.
        if (redirect) begin
            kill_d = inflight_d;
            if (ir_addr_valid && !ir_addr_ready) begin
                redirect_pending_d = 1'b1;
                redirect_pc_d      = target;
            end else begin
                redirect_pending_d = 1'b0;
                pc_next_d          = target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_next_q          <= RESET_ADDR;
            redirect_pc_q      <= RESET_ADDR;
            inflight_q         <= '0;
            kill_q             <= '0;
            redirect_pending_q <= 1'b0;
            issue_en_q         <= 1'b0;
        end else begin
            pc_next_q          <= pc_next_d;
            redirect_pc_q      <= redirect_pc_d;
            inflight_q         <= inflight_d;
            kill_q             <= kill_d;
            redirect_pending_q <= redirect_pending_d;
            issue_en_q         <= 1'b1;
        end
    end

    // Addresses of accepted requests, matched to responses in order.
    fetch_fifo #(
        .WIDTH (PC_WIDTH),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (addr_hs),
        .pop_i   (resp_ok),
        .flush_i (1'b0),
        .din_i   (pc_next_q),
        .dout_o  (pcq_head),
        .empty_o (pcq_empty),
        .full_o  (pcq_full),
        .count_o (pcq_count)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (resp_keep),
        .pop_i   (inst_pop),
        .flush_i (redirect),
        .din_i   (push_entry),
        .dout_o  (head_entry),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign inst_valid = !fifo_empty;
    assign inst       = head_entry.inst;
    assign inst_pc    = head_entry.pc;

    a_resp_expected: assert property (@(posedge clk) disable iff (!rst)
        ir_data_valid |-> !pcq_empty);
    a_inflight_track: assert property (@(posedge clk) disable iff (!rst)
        pcq_count == inflight_q);
    a_kill_bound: assert property (@(posedge clk) disable iff (!rst)
        kill_q <= inflight_q);
    a_pcq_space: assert property (@(posedge clk) disable iff (!rst)
        addr_hs |-> (!pcq_full || resp_ok));
    a_fifo_space: assert property (@(posedge clk) disable iff (!rst)
        (resp_keep && fifo_full) |-> inst_pop);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed phases plus a randomized run of fetch_unit against a stream-level model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int unsigned PW    = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ir_addr_valid, ir_addr_ready;
    logic [PW-1:0] ir_addr;
    logic          ir_data_valid, ir_data_ready;
    logic [IW-1:0] ir_data;
    logic          inst_valid, inst_ready;
    logic [IW-1:0] inst;
    logic [PW-1:0] inst_pc;
    logic          redirect;
    logic [PW-1:0] redirect_pc;

    fetch_unit #(
        .PC_WIDTH   (PW),
        .INST_WIDTH (IW),
        .RESET_ADDR (PW'(0)),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ir_addr_valid (ir_addr_valid),
        .ir_addr_ready (ir_addr_ready),
        .ir_addr       (ir_addr),
        .ir_data_valid (ir_data_valid),
        .ir_data_ready (ir_data_ready),
        .ir_data       (ir_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Bus model: accepted addresses with the cycle their response becomes due.
    logic [PW-1:0] bus_q[$];
    int            bus_due[$];
    int            lat_min = 1, lat_max = 1;
    int            ready_pct = 100, iready_pct = 100;

    // Reference model: expected next issue address and next decoded PC.
    logic [PW-1:0] exp_issue, exp_pc, redir_target;
    bit            redir_held, prev_redirect, stall_prev;
    int            issued, consumed, hs10;
    bit            last_hs, last_resp;

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        ir_addr_ready = 1'b0;
        ir_data_valid = 1'b0;
        ir_data = '0;
        inst_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ir_addr_valid", 64'(ir_addr_valid), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        bus_q.delete();
        bus_due.delete();
        exp_issue = '0;
        exp_pc = '0;
        redir_target = '0;
        redir_held = 1'b0;
        prev_redirect = 1'b0;
        stall_prev = 1'b0;
        issued = 0;
        consumed = 0;
        hs10 = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive, sample #1 later, check against the model, advance the model.
    task automatic step(input bit do_redir, input logic [PW-1:0] tgt);
        bit            hs, pop;
        logic [PW-1:0] tgt_al;
        @(negedge clk);
        ir_addr_ready = ($urandom_range(99) < 32'(ready_pct));
        inst_ready    = ($urandom_range(99) < 32'(iready_pct));
        redirect      = do_redir;
        redirect_pc   = tgt;
        if (bus_q.size() > 0 && bus_due[0] <= cyc) begin
            ir_data_valid = 1'b1;
            ir_data       = mem_word(bus_q[0]);
        end else begin
            ir_data_valid = 1'b0;
            ir_data       = $urandom;
        end
        #1;
        if (prev_redirect) check("inst_valid_after_redirect", 64'(inst_valid), 64'd0);
        if (stall_prev || redir_held) check("ir_addr_valid_hold", 64'(ir_addr_valid), 64'd1);
        if (ir_addr_valid) check("ir_addr", 64'(ir_addr), 64'(exp_issue));
        hs  = ir_addr_valid && ir_addr_ready;
        pop = inst_valid && inst_ready;
        if (pop) begin
            check("inst_pc", 64'(inst_pc), 64'(exp_pc));
            check("inst", 64'(inst), 64'(mem_word(exp_pc)));
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        last_resp = ir_data_valid;
        last_hs   = hs;
        if (ir_data_valid) begin
            void'(bus_q.pop_front());
            void'(bus_due.pop_front());
        end
        if (hs) begin
            if (ir_addr == 32'h10) hs10++;
            bus_q.push_back(ir_addr);
            bus_due.push_back(cyc + $urandom_range(lat_max, lat_min));
            issued++;
            if (redir_held) begin
                exp_issue  = redir_target;
                redir_held = 1'b0;
            end else begin
                exp_issue = exp_issue + 32'd4;
            end
        end
        check("outstanding_le_depth", 64'(bus_q.size() <= DEPTH), 64'd1);
        if (do_redir) begin
            tgt_al = {tgt[PW-1:2], 2'b00};
            exp_pc = tgt_al;
            if (ir_addr_valid && !ir_addr_ready) begin
                redir_held   = 1'b1;
                redir_target = tgt_al;
            end else begin
                exp_issue  = tgt_al;
                redir_held = 1'b0;
            end
        end
        prev_redirect = do_redir;
        stall_prev    = ir_addr_valid && !ir_addr_ready;
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming from reset with an always-ready single-cycle bus.
        lat_min = 1; lat_max = 1; ready_pct = 100; iready_pct = 100;
        do_reset();
        step(1'b0, '0);
        check("first_issue_valid", 64'(ir_addr_valid), 64'd1);
        check("first_issue_addr", 64'(ir_addr), 64'h0);
        check("ir_data_ready_tied", 64'(ir_data_ready), 64'd1);
        step(1'b0, '0);
        check("lat_no_inst_yet", 64'(inst_valid), 64'd0);
        step(1'b0, '0);
        check("lat_first_inst", 64'(inst_valid), 64'd1);
        repeat (17) step(1'b0, '0);
        check("throughput_consumed", 64'(consumed), 64'd18);

        // Decoder stalled: credit caps outstanding work, then drains in order.
        iready_pct = 0;
        do_reset();
        repeat (10) step(1'b0, '0);
        check("stall_issued", 64'(issued), 64'(DEPTH));
        check("stall_valid_low", 64'(ir_addr_valid), 64'd0);
        iready_pct = 100;
        repeat (10) step(1'b0, '0);
        check("drain_consumed", 64'(consumed), 64'd10);

        // Bus not ready while 0x10 is presented.
        do_reset();
        repeat (4) step(1'b0, '0);
        ready_pct = 0;
        repeat (5) begin
            step(1'b0, '0);
            check("hold_addr_0x10", 64'(ir_addr), 64'h10);
        end
        ready_pct = 100;
        repeat (6) step(1'b0, '0);
        check("accepted_0x10_once", 64'(hs10), 64'd1);

        // Redirect with two fetches in flight.
        lat_min = 3; lat_max = 3;
        do_reset();
        repeat (2) step(1'b0, '0);
        check("two_in_flight", 64'(bus_q.size()), 64'd2);
        step(1'b1, 32'h103);
        consumed = 0;
        repeat (12) step(1'b0, '0);
        check("after_redirect_delivered", 64'(consumed > 0), 64'd1);

        // Redirect coinciding with a response and an address handshake.
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (2) step(1'b0, '0);
        step(1'b1, 32'h200);
        check("coincident_hs_resp", 64'({last_hs, last_resp}), 64'b11);
        repeat (10) step(1'b0, '0);

        // Redirect during a stalled request, then a second redirect.
        do_reset();
        repeat (2) step(1'b0, '0);
        ready_pct = 0;
        step(1'b1, 32'h300);
        step(1'b1, 32'h406);
        ready_pct = 100;
        step(1'b0, '0);
        check("held_req_accepted", 64'(last_hs), 64'd1);
        repeat (10) step(1'b0, '0);
        check("second_target_stream", 64'(exp_pc >= 32'h404 && exp_pc < 32'h500), 64'd1);

        // Randomized traffic, random redirects (one near wraparound), mid-run reset.
        lat_min = 1; lat_max = 4; ready_pct = 70; iready_pct = 60;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if (i == 700)
                step(1'b1, 32'hFFFF_FFE7);
            else if ($urandom_range(99) < 4)
                step(1'b1, $urandom & 32'h0000_3FFF);
            else
                step(1'b0, '0);
        end
        check("random_progress", 64'(consumed > 100), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
